error_combiner_pipe: RTL

Pipelined, parametrised successor to the 4-input weighted phase-error combiner in the ADPLL loop-filter path. Combines NUM_CH signed phase-detector errors, each multiplied by a runtime-programmable signed weight. The sum is divided by 2^SHIFT, then saturated to ERROR_WIDTH. Weights are stored in an internal register file, samples are qualified by valid, and saturation events are counted for loop-health monitoring.

---
 rtl/error_combiner_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/error_combiner_pipe.sv
// Three-stage weighted phase-error combiner: per-channel products, adder tree, shift+saturate.
// Optional rounding before the shift is enabled by defining ERROR_COMBINER_ROUND_EN.

module error_combiner_lane #(
    parameter int EW = 8,
    parameter int WW = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en,
    input  logic [WW-1:0]    weight,
    input  logic [EW-1:0]    error,
    output logic [EW+WW-1:0] prod
);
    localparam int PW = EW + WW;

    logic signed [PW-1:0] w_x, e_x;
    assign w_x = PW'($signed(weight));
    assign e_x = PW'($signed(error));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)  prod <= '0;
        else if (en)  prod <= w_x * e_x;
    end
endmodule

module error_combiner_pipe #(
    parameter int NUM_CH       = 4,
    parameter int ERROR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int SHIFT        = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          valid_i,
    input  logic [NUM_CH*ERROR_WIDTH-1:0] error_i,
    input  logic                          weight_wr_i,
    input  logic [$clog2(NUM_CH)-1:0]     weight_addr_i,
    input  logic [WEIGHT_WIDTH-1:0]       weight_data_i,
    input  logic                          sat_clr_i,
    output logic                          valid_o,
    output logic [ERROR_WIDTH-1:0]        error_comb_o,
    output logic                          sat_o,
    output logic [CNT_WIDTH-1:0]          sat_count_o
);
    localparam int STAGES = 3;
    localparam int PW     = ERROR_WIDTH + WEIGHT_WIDTH;
    localparam int SW     = PW + $clog2(NUM_CH);
`ifdef ERROR_COMBINER_ROUND_EN
    localparam int RW     = SW + 1;
    localparam logic signed [RW-1:0] RND = RW'((1 << SHIFT) >> 1);
`else
    localparam int RW     = SW;
`endif
    localparam logic signed [RW-1:0] MAXV = RW'(2**(ERROR_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic [STAGES:0]                    vld_pipe;
    logic [NUM_CH-1:0][WEIGHT_WIDTH-1:0] weight_q;
    logic [NUM_CH-1:0][PW-1:0]           prod;
    logic signed [SW-1:0]               sum_c, sum_q;
    logic signed [RW-1:0]               acc_c, res_c;
    logic                               sat_hi, sat_lo;

    assign vld_pipe[0] = valid_i;
    assign valid_o     = vld_pipe[STAGES];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) vld_pipe[STAGES:1] <= '0;
        else         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Lanes sample the registered weights, so a same-cycle write only affects later samples.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_CH; k++) weight_q[k] <= WEIGHT_WIDTH'(1);
        end else if (weight_wr_i && (int'(weight_addr_i) < NUM_CH)) begin
            weight_q[weight_addr_i] <= weight_data_i;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        error_combiner_lane #(.EW(ERROR_WIDTH), .WW(WEIGHT_WIDTH)) u_lane (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en      (vld_pipe[0]),
            .weight  (weight_q[k]),
            .error   (error_i[k*ERROR_WIDTH +: ERROR_WIDTH]),
            .prod    (prod[k])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NUM_CH; k++) sum_c = sum_c + SW'($signed(prod[k]));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)          sum_q <= '0;
        else if (vld_pipe[1]) sum_q <= sum_c;
    end

    always_comb begin
`ifdef ERROR_COMBINER_ROUND_EN
        acc_c = RW'(sum_q) + RND;
`else
        acc_c = sum_q;
`endif
        res_c  = acc_c >>> SHIFT;
        sat_hi = res_c > MAXV;
        sat_lo = res_c < MINV;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_comb_o <= '0;
            sat_o        <= 1'b0;
        end else if (vld_pipe[2]) begin
            error_comb_o <= sat_hi ? MAXV[ERROR_WIDTH-1:0] :
                            sat_lo ? MINV[ERROR_WIDTH-1:0] : res_c[ERROR_WIDTH-1:0];
            sat_o        <= sat_hi | sat_lo;
        end
    end

    // Counts on the edge that publishes a clipped result, so the count is current with sat_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            sat_count_o <= '0;
        else if (sat_clr_i)
            sat_count_o <= '0;
        else if (vld_pipe[2] && (sat_hi | sat_lo) && (sat_count_o != '1))
            sat_count_o <= sat_count_o + 1'b1;
    end
endmodule
